// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory-controller port between the instruction
// fetch requester (I) and the data requester (D). D normally has priority.
// A streak limit stops fetch from starving. Only one transaction is in flight
// at a time, and an access that hangs is completed with an error acknowledge.
module mem_port_arbiter #(
  parameter int D_MAX_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_i_req,
  input  logic [31:0] i_i_addr,
  output logic [31:0] o_i_rdata,
  output logic        o_i_ack,
  output logic        o_i_err,
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [1:0]  i_d_width,
  input  logic        i_d_we,
  input  logic        i_d_zeroextend,
  output logic [31:0] o_d_rdata,
  output logic        o_d_ack,
  output logic        o_d_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_width,
  output logic        o_mem_we,
  output logic        o_mem_zeroextend,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_busy
);

  localparam int STREAK_W = (D_MAX_STREAK < 1) ? 1 : $clog2(D_MAX_STREAK + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state_r;
  logic                owner_d_r;      // 1: data requester owns the port
  logic [STREAK_W-1:0] streak_r;       // D grants in a row while fetch waited
  logic [TMO_W-1:0]    tmo_cnt_r;
  logic                mem_req_r;
  logic [31:0]         mem_addr_r;
  logic [31:0]         mem_wdata_r;
  logic [1:0]          mem_width_r;
  logic                mem_we_r;
  logic                mem_zext_r;

  logic streak_full_s;
  logic d_wins_s;
  logic i_wins_s;
  logic tmo_hit_s;
  logic done_s;
  logic err_s;

  assign streak_full_s = (streak_r == STREAK_W'(D_MAX_STREAK));
  assign d_wins_s      = i_d_req && !(i_i_req && streak_full_s);
  assign i_wins_s      = !d_wins_s && i_i_req;
  assign tmo_hit_s     = (TIMEOUT_CYCLES != 0) && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // A transaction ends when memory acks or the timeout expires. A cycle with
  // reset asserted drops the transaction and gives no acknowledge.
  assign done_s = (state_r == ST_BUSY) && i_rst_n && (i_mem_ack || tmo_hit_s);
  assign err_s  = done_s && !i_mem_ack;

  assign o_mem_req        = mem_req_r;
  assign o_mem_addr       = mem_addr_r;
  assign o_mem_wdata      = mem_wdata_r;
  assign o_mem_width      = mem_width_r;
  assign o_mem_we         = mem_we_r;
  assign o_mem_zeroextend = mem_zext_r;
  assign o_busy           = (state_r == ST_BUSY);

  // Route the completion, in the same cycle, to whichever requester owns the port.
  always_comb begin
    o_i_ack   = 1'b0;
    o_i_err   = 1'b0;
    o_i_rdata = 32'h0000_0000;
    o_d_ack   = 1'b0;
    o_d_err   = 1'b0;
    o_d_rdata = 32'h0000_0000;
    if (done_s) begin
      if (owner_d_r) begin
        o_d_ack   = 1'b1;
        o_d_err   = err_s;
        o_d_rdata = err_s ? 32'h0000_0000 : i_mem_rdata;
      end else begin
        o_i_ack   = 1'b1;
        o_i_err   = err_s;
        o_i_rdata = err_s ? 32'h0000_0000 : i_mem_rdata;
      end
    end else begin
      o_i_ack = 1'b0;
      o_d_ack = 1'b0;
    end
  end

  // Control FSM: grant in IDLE, hold the port payload in BUSY, retire on ack or timeout.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      owner_d_r   <= 1'b0;
      streak_r    <= '0;
      tmo_cnt_r   <= '0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_width_r <= 2'b00;
      mem_we_r    <= 1'b0;
      mem_zext_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tmo_cnt_r <= '0;
          if (d_wins_s) begin
            state_r     <= ST_BUSY;
            owner_d_r   <= 1'b1;
            mem_req_r   <= 1'b1;
            mem_addr_r  <= i_d_addr;
            mem_wdata_r <= i_d_wdata;
            mem_width_r <= i_d_width;
            mem_we_r    <= i_d_we;
            mem_zext_r  <= i_d_zeroextend;
            if (i_i_req) begin
              streak_r <= streak_full_s ? streak_r : streak_r + STREAK_W'(1);
            end else begin
              streak_r <= '0;
            end
          end else if (i_wins_s) begin
            state_r     <= ST_BUSY;
            owner_d_r   <= 1'b0;
            mem_req_r   <= 1'b1;
            mem_addr_r  <= i_i_addr;
            mem_wdata_r <= 32'h0000_0000;
            mem_width_r <= 2'b10;
            mem_we_r    <= 1'b0;
            mem_zext_r  <= 1'b0;
            streak_r    <= '0;
          end else begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (done_s) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
            tmo_cnt_r <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
          tmo_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
